// File: rtl/fetch_queue.sv
// Fetch-to-decode bundle queue: circular FIFO with bubble drop on push and redirect flush.
// The bundle's valid flag sits in the MSB of the packed fet_bundle_t.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int W     = 170
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_bundle,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_bundle,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic          push, pop, hs_in;

  assign in_ready   = (count != CW'(DEPTH));
  assign out_valid  = (count != '0);
  assign out_bundle = mem[rptr];

  // A bubble (bundle.valid=0) still completes the handshake but writes nothing.
  assign hs_in = in_valid & in_ready & ~flush;
  assign push  = hs_in & in_bundle[W-1];
  assign pop   = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr] <= in_bundle;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 8;
  localparam int W     = 170;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_bundle = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_bundle;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] q[$];
  logic [63:0]  seq_pc = 64'h8000;

  fetch_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bundle(in_bundle),
    .out_valid(out_valid), .out_ready(out_ready), .out_bundle(out_bundle),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Layout: {valid, pc[63:0], pnpc[63:0], ir, pat, flags}; low fields random.
  function automatic logic [W-1:0] mk(input logic v, input logic [63:0] pc);
    logic [W-1:0] b;
    b = W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    b[W-1]      = v;
    b[W-2 -: 64] = pc;
    b[W-66 -: 64] = pc + 64'd4;
    return b;
  endfunction

  task automatic drive(input logic iv, input logic v, input logic [63:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    in_bundle = mk(v, pc);
    out_ready = ordy;
    flush     = fl;
  endtask

  // Check outputs against the model, then advance one clock.
  task automatic cyc();
    logic do_push, do_pop, fl;
    logic [W-1:0] b;
    chk("count", W'(count), W'(q.size()));
    chk("out_valid", W'(out_valid), W'(q.size() != 0));
    chk("in_ready", W'(in_ready), W'(q.size() < DEPTH));
    if (q.size() != 0) chk("out_bundle", out_bundle, q[0]);
    fl      = flush;
    b       = in_bundle;
    do_pop  = !fl && out_ready && q.size() != 0;
    do_push = !fl && in_valid && q.size() < DEPTH && b[W-1];
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(b);
    end
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", W'(count), W'(0));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    rst = 1'b0;

    // Fill from the very first edge after reset, then drain in order.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 64'h1000 + 64'(4 * i), 0, 0);
      cyc();
    end
    chk("fill_count", W'(count), W'(8));
    chk("fill_in_ready", W'(in_ready), W'(0));
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 1, 0);
      chk("fill_pc", W'(out_bundle[W-2 -: 64]), W'(64'h1000 + 64'(4 * i)));
      cyc();
    end
    chk("drain_count", W'(count), W'(0));

    // Streaming at occupancy 3.
    for (int i = 0; i < 3; i++) begin drive(1, 1, seq_pc, 0, 0); seq_pc += 4; cyc(); end
    for (int i = 0; i < 20; i++) begin drive(1, 1, seq_pc, 1, 0); seq_pc += 4; cyc(); end
    chk("stream_count", W'(count), W'(3));

    // Full with pop: no push accepted, count drops.
    for (int i = 0; i < 5; i++) begin drive(1, 1, seq_pc, 0, 0); seq_pc += 4; cyc(); end
    drive(1, 1, 64'h4444, 1, 0);
    cyc();
    chk("full_pop_count", W'(count), W'(DEPTH - 1));

    // Flush at count 5 with a coincident push of 0x2000.
    drive(0, 0, 0, 1, 0); cyc(); cyc();
    chk("pre_flush_count", W'(count), W'(5));
    drive(1, 1, 64'h2000, 1, 1);
    cyc();
    chk("flush_count", W'(count), W'(0));
    chk("flush_out_valid", W'(out_valid), W'(0));

    // Bubble drop.
    drive(1, 1, seq_pc, 0, 0); seq_pc += 4; cyc();
    drive(1, 0, 64'h3000, 0, 0); cyc();
    chk("bubble_count", W'(count), W'(1));
    drive(0, 0, 0, 1, 0); cyc();

    // Wrap: 13 pushes, 10 pops, leaving pushes 11-13.
    for (int i = 0; i < 3; i++) begin drive(1, 1, 64'h5000 + 64'(4 * i), 0, 0); cyc(); end
    for (int i = 3; i < 13; i++) begin drive(1, 1, 64'h5000 + 64'(4 * i), 1, 0); cyc(); end
    chk("wrap_count", W'(count), W'(3));
    for (int i = 10; i < 13; i++) begin
      drive(0, 0, 0, 1, 0);
      chk("wrap_pc", W'(out_bundle[W-2 -: 64]), W'(64'h5000 + 64'(4 * i)));
      cyc();
    end

    // Asynchronous reset between edges at count 4.
    for (int i = 0; i < 4; i++) begin drive(1, 1, seq_pc, 0, 0); seq_pc += 4; cyc(); end
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    chk("arst_count", W'(count), W'(0));
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_in_ready", W'(in_ready), W'(1));
    q.delete();
    rst = 1'b0;
    cyc();

    // Random traffic with phase-varying drain pressure.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 400; i++) begin
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, seq_pc,
              $urandom_range(0, 3) < ph + 1, $urandom_range(0, 63) == 0);
        seq_pc += 4;
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
